// File: rtl/innerproduct_stream.sv
// innerproduct_stream: streaming inner product with loadable coefficients.
// One feature per beat, one hprime result per NFEAT-word frame.
module innerproduct_stream #(
   parameter int unsigned      DATA_W    = 32,
   parameter int unsigned      NFEAT     = 41,
   parameter logic [NFEAT-1:0] SKIP_MASK = NFEAT'(2),
   parameter int unsigned      IDX_W     = $clog2(NFEAT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              coef_we,
   input  logic [IDX_W-1:0]  coef_addr,
   input  logic [DATA_W-1:0] coef_wdata,
   output logic              coef_busy,
   input  logic              x_valid,
   output logic              x_ready,
   input  logic [DATA_W-1:0] x_data,
   input  logic              x_last,
   output logic              y_valid,
   input  logic              y_ready,
   output logic [DATA_W-1:0] y_data,
   output logic              frame_err
);

   typedef enum logic {
      COLLECT = 1'b0,
      DONE    = 1'b1
   } state_e;

   state_e            state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] acc_d;
   logic [DATA_W-1:0] y_data_q;
   logic              frame_err_q;
   logic [DATA_W-1:0] coef_q [NFEAT];

   logic [DATA_W-1:0] prod;
   logic [DATA_W-1:0] term;
   logic              beat;
   logic              is_last;
   logic              coef_wr;

   assign x_ready   = (state_q == COLLECT);
   assign y_valid   = (state_q == DONE);
   assign coef_busy = (idx_q != '0) || (state_q == DONE);
   assign y_data    = y_data_q;
   assign frame_err = frame_err_q;

   assign beat    = x_valid && x_ready;
   assign is_last = (idx_q == IDX_W'(NFEAT - 1));
   assign coef_wr = coef_we && !coef_busy
                    && ({1'b0, coef_addr} < (IDX_W + 1)'(NFEAT));

   // Next partial sum: bias slot seeds acc, other slots add a truncated product
   always_comb begin
      prod  = x_data * coef_q[idx_q];
      term  = SKIP_MASK[idx_q] ? '0 : prod;
      acc_d = (idx_q == '0) ? coef_q[0] : acc_q + term;
   end

   // Coefficient table, writable only between frames
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NFEAT); i++) begin
            coef_q[i] <= '0;
         end
      end else if (coef_wr) begin
         coef_q[coef_addr] <= coef_wdata;
      end
   end

   // Frame FSM: count beats, accumulate, hold result until accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         acc_q       <= '0;
         y_data_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         unique case (state_q)
            COLLECT: begin
               if (beat) begin
                  acc_q <= acc_d;
                  if (x_last != is_last) begin
                     frame_err_q <= 1'b1;
                  end
                  if (is_last) begin
                     idx_q    <= '0;
                     state_q  <= DONE;
                     y_data_q <= acc_d;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            DONE: begin
               if (y_ready) begin
                  state_q <= COLLECT;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_innerproduct_stream.sv
// tb_innerproduct_stream: randomized scoreboard bench for innerproduct_stream.
// Two instances differ only in SKIP_MASK; both share all inputs.
module tb_innerproduct_stream;

   localparam int N = 41;
   localparam logic [N-1:0] M1 = 41'h2;
   localparam logic [N-1:0] M2 = 41'h6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        coef_we;
   logic [5:0]  coef_addr;
   logic [31:0] coef_wdata;
   logic        x_valid;
   logic [31:0] x_data;
   logic        x_last;
   logic        y_ready;

   logic        coef_busy, x_ready, y_valid, frame_err;
   logic [31:0] y_data;
   logic        coef_busy2, x_ready2, y_valid2, frame_err2;
   logic [31:0] y_data2;

   logic [31:0] xs [N];
   logic [31:0] cm [N];
   logic [31:0] q1 [$];
   logic [31:0] q2 [$];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   innerproduct_stream #(.DATA_W(32), .NFEAT(N), .SKIP_MASK(M1)) dut (
      .clk(clk), .rst_n(rst_n),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_busy(coef_busy),
      .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
      .frame_err(frame_err)
   );

   innerproduct_stream #(.DATA_W(32), .NFEAT(N), .SKIP_MASK(M2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .coef_busy(coef_busy2),
      .x_valid(x_valid), .x_ready(x_ready2), .x_data(x_data), .x_last(x_last),
      .y_valid(y_valid2), .y_ready(y_ready), .y_data(y_data2),
      .frame_err(frame_err2)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: bias plus sum of unmasked products, all modulo 2^32
   function automatic logic [31:0] ref_sum(logic [N-1:0] mask);
      logic [31:0] s;
      s = cm[0];
      for (int i = 1; i < N; i++) begin
         if (!mask[i]) s = s + xs[i] * cm[i];
      end
      return s;
   endfunction

   // Monitor: compare every accepted result against the scoreboard
   always @(negedge clk) begin
      if (rst_n && y_valid && y_ready) begin
         if (q1.size() == 0) chk("spurious_y", 32'd1, 32'd0);
         else chk("y_data", y_data, q1.pop_front());
      end
      if (rst_n && y_valid2 && y_ready) begin
         if (q2.size() == 0) chk("spurious_y2", 32'd1, 32'd0);
         else chk("y_data2", y_data2, q2.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t = 0;
      while (y_valid && t < 100) begin
         tick();
         t++;
      end
      if (y_valid) chk("drain_timeout", {31'd0, y_valid}, 32'd0);
   endtask

   task automatic coef_write(logic [5:0] a, logic [31:0] d, bit lands);
      int t = 0;
      while (coef_busy && t < 200) begin
         tick();
         t++;
      end
      if (coef_busy) chk("busy_timeout", {31'd0, coef_busy}, 32'd0);
      coef_we    = 1'b1;
      coef_addr  = a;
      coef_wdata = d;
      tick();
      coef_we = 1'b0;
      if (lands) cm[a] = d;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!x_ready && t < 200) begin
         tick();
         t++;
      end
      if (!x_ready) chk("x_ready_timeout", {31'd0, x_ready}, 32'd1);
   endtask

   task automatic send_frame(int last_pos, bit gaps, int wr_beat,
                             logic [5:0] wa, logic [31:0] wd);
      q1.push_back(ref_sum(M1));
      q2.push_back(ref_sum(M2));
      for (int i = 0; i < N; i++) begin
         if (gaps && i > 0) begin
            repeat ($urandom_range(5, 1)) tick();
         end
         x_valid = 1'b1;
         x_data  = xs[i];
         x_last  = (i == last_pos);
         if (i == wr_beat) begin
            coef_we    = 1'b1;
            coef_addr  = wa;
            coef_wdata = wd;
         end
         wait_ready();
         if (i == wr_beat) chk("busy_at_write", {31'd0, coef_busy}, {31'd0, i != 0});
         if (i == N - 1) chk("y_valid_before_last", {31'd0, y_valid}, 32'd0);
         tick();
         coef_we = 1'b0;
         x_valid = 1'b0;
         x_last  = 1'b0;
      end
      if (wr_beat == 0 && wa < N) cm[wa] = wd;
      chk("y_valid_latency", {31'd0, y_valid}, 32'd1);
      chk("x_ready_in_done", {31'd0, x_ready}, 32'd0);
   endtask

   task automatic rand_xs();
      for (int i = 0; i < N; i++) xs[i] = $urandom;
   endtask

   task automatic load_all();
      for (int i = 0; i < N; i++) coef_write(6'(i), cm[i], 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ya;
      logic [31:0] yb;
      rst_n = 1'b0;
      coef_we = 1'b0;
      coef_addr = '0;
      coef_wdata = '0;
      x_valid = 1'b0;
      x_data = '0;
      x_last = 1'b0;
      y_ready = 1'b1;
      for (int i = 0; i < N; i++) cm[i] = '0;
      repeat (2) tick();
      chk("rst_y_valid", {31'd0, y_valid}, 32'd0);
      chk("rst_y_data", y_data, 32'd0);
      chk("rst_x_ready", {31'd0, x_ready}, 32'd1);
      chk("rst_coef_busy", {31'd0, coef_busy}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      #2 rst_n = 1'b1;
      tick();

      // 1: basic frame
      cm[0] = 5;
      cm[1] = 100;
      for (int i = 2; i < N; i++) cm[i] = 1;
      load_all();
      for (int i = 0; i < N; i++) xs[i] = i;
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);
      chk("t1_y_data", y_data, 32'd824);
      chk("t1_frame_err", {31'd0, frame_err}, 32'd0);

      // 2: output back-pressure
      drain();
      y_ready = 1'b0;
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("t2_hold_valid", {31'd0, y_valid}, 32'd1);
         chk("t2_hold_data", y_data, 32'd824);
         chk("t2_hold_xrdy", {31'd0, x_ready}, 32'd0);
      end
      y_ready = 1'b1;
      tick();
      chk("t2_xrdy_after", {31'd0, x_ready}, 32'd1);
      rand_xs();
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);

      // 3: truncation/wrap and skip mask
      for (int i = 0; i < N; i++) cm[i] = '0;
      cm[2] = 32'hFFFF_FFFF;
      load_all();
      rand_xs();
      xs[2] = 2;
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);
      chk("t3_wrap", y_data, 32'hFFFF_FFFE);
      chk("t3_skip", y_data2, 32'd0);

      // 4: writes while busy ignored; bias write on beat 0 is deferred
      for (int i = 0; i < N; i++) cm[i] = $urandom;
      load_all();
      rand_xs();
      send_frame(N - 1, 1'b0, 7, 6'd3, 32'h1234_5678);
      coef_write(6'd45, 32'hDEAD_BEEF, 1'b0);
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);
      coef_write(6'd3, 32'h1234_5678, 1'b1);
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);
      drain();
      send_frame(N - 1, 1'b0, 0, 6'd0, 32'h0000_0777);
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);

      // 5: misplaced x_last, then gapped vs gapless
      rand_xs();
      send_frame(20, 1'b0, -1, 6'd0, 32'd0);
      chk("t5_frame_err", {31'd0, frame_err}, 32'd1);
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);
      ya = y_data;
      send_frame(N - 1, 1'b1, -1, 6'd0, 32'd0);
      yb = y_data;
      chk("t5_gap_same", yb, ya);
      chk("t5_err_sticky", {31'd0, frame_err}, 32'd1);

      // random frames
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N; i++) cm[i] = $urandom;
         load_all();
         rand_xs();
         send_frame(N - 1, f[0], -1, 6'd0, 32'd0);
      end

      // 6: reset mid-frame
      drain();
      for (int i = 0; i < 15; i++) begin
         x_valid = 1'b1;
         x_data  = $urandom;
         x_last  = 1'b0;
         wait_ready();
         tick();
      end
      x_valid = 1'b0;
      chk("t6_busy_mid", {31'd0, coef_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_y_valid", {31'd0, y_valid}, 32'd0);
      chk("t6_y_data", y_data, 32'd0);
      chk("t6_x_ready", {31'd0, x_ready}, 32'd1);
      chk("t6_busy", {31'd0, coef_busy}, 32'd0);
      chk("t6_frame_err", {31'd0, frame_err}, 32'd0);
      for (int i = 0; i < N; i++) cm[i] = '0;
      #2 rst_n = 1'b1;
      tick();
      rand_xs();
      send_frame(N - 1, 1'b0, -1, 6'd0, 32'd0);
      chk("t6_zero", y_data, 32'd0);

      begin
         int t = 0;
         while ((q1.size() + q2.size()) != 0 && t < 100) begin
            tick();
            t++;
         end
      end
      chk("scoreboard_empty", q1.size() + q2.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/innerproduct_stream.md
Name: innerproduct_stream

Overview:
Sequential, parametrised successor of the fixed 41-term combinational inner-product block in the logistic-regression linebuffer path.
- Accepts one feature word per handshake and multiplies it by a runtime-loadable coefficient.
- Accumulates the result and emits hprime once per frame through a valid/ready output.
- Sits between the linebuffer feature stream and the sigmoid/threshold stage.
- Replaces the compile-time theta header with a write port, so models can be swapped without resynthesis.

Parameters:
DATA_W, 32, width of features, coefficients, products and result (all modulo 2^DATA_W)
NFEAT, 41, words per frame including the bias slot at index 0
SKIP_MASK, 41'h2, bit i=1 forces the term at index i to 0 (index 1 skipped by default); bit 0 ignored
IDX_W, $clog2(NFEAT), index/address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
coef_we  in  1  coefficient write strobe
coef_addr  in  IDX_W  coefficient index 0..NFEAT-1
coef_wdata  in  DATA_W  coefficient value (index 0 = bias THETA0)
coef_busy  out  1  high while a frame is in progress; writes are ignored while high
x_valid  in  1  feature word valid
x_ready  out  1  block can accept a feature
x_data  in  DATA_W  feature word
x_last  in  1  source marks the final word of a frame
y_valid  out  1  result valid
y_ready  in  1  downstream accepts result
y_data  out  DATA_W  hprime
frame_err  out  1  sticky: x_last disagreed with the internal index

Behaviour:
- Reset: the following are async-cleared while rst_n=0; release is synchronised externally.
  - State=COLLECT, idx=0, acc=0.
  - All coefficients=0.
  - y_valid=0, y_data=0, x_ready=1, coef_busy=0, frame_err=0.
- States: COLLECT and DONE.
  - x_ready = (state==COLLECT).
  - y_valid = (state==DONE).
- Beat: x_valid&&x_ready at index idx.
  - idx==0: acc <= coef[0]. x_data is ignored (bias slot).
  - idx>0: acc <= acc + (SKIP_MASK[idx] ? 0 : lowDATA_W(x_data*coef[idx])). Unsigned multiply, truncated to DATA_W bits; additions wrap modulo 2^DATA_W.
  - idx increments each beat.
  - Beat at idx==NFEAT-1: idx <= 0, state <= DONE, y_data <= final sum (same value acc takes).
- Latency: y_valid rises one cycle after the last beat is accepted.
- DONE: y_data and y_valid are held stable until y_ready=1. On the handshake cycle, state <= COLLECT, so x_ready=1 the next cycle. There is no same-cycle pass-through. Maximum throughput is NFEAT+1 cycles per frame.
- x_last checking:
  - If x_last=1 on a beat with idx!=NFEAT-1, or x_last=0 on the beat with idx==NFEAT-1, frame_err <= 1.
  - frame_err stays set until reset.
  - Framing is always driven by the internal index; x_last never alters the count.
- coef_busy = (idx!=0) || (state==DONE).
  - coef_we with coef_busy=0 and coef_addr<NFEAT: the write lands at the clock edge.
  - The write is used by the next frame's beats.
  - Out-of-range address: ignored.
  - coef_we in the same cycle as the idx==0 beat (coef_busy=0): the write lands and the beat reads the old coef[0]; the new value applies from the next frame.
- x_valid held low mid-frame: state and acc hold indefinitely. No timeout.
- Reset mid-frame or in DONE: partial sum is discarded, coefficients return to 0, and no y_valid is produced.

Test Plan:
1. Load coef[0]=5, coef[2..40]=1, coef[1]=100; stream x[i]=i (i=0..40), x_last on beat 40 -> y_data=5+sum(2..40)=824, y_valid one cycle after the last beat, frame_err=0.
2. Same frame with y_ready held 0 for 10 cycles -> y_valid/y_data=824 stable, x_ready=0 throughout; after y_ready=1, the next frame is accepted the following cycle.
3. coef[2]=32'hFFFF_FFFF, x[2]=2, all other coefs 0 -> y_data=32'hFFFF_FFFE (truncate/wrap check). Same coefficients with SKIP_MASK bit 2 set -> 0.
4. Write coef[3] at beat index 7 -> coef_busy=1, write ignored, result unchanged; repeat the write after y handshake -> the next frame reflects it.
5. x_last asserted on beat 20 -> frame_err=1 sticky, frame still completes at beat 40; x_valid gaps of 1–5 cycles mid-frame -> same sum as the gapless run.
6. rst_n pulsed low at beat 15 -> all outputs/coefs at reset values asynchronously; after release a new frame (all coefs 0) -> y_data=0.
